// File: rtl/sprite_pkg.sv
// Shared constants and FSM encoding for the double-buffered sprite store.
package sprite_pkg;
  localparam int SPR_LINES   = 48;
  localparam int SPR_WIDTH   = 64;
  localparam int FRAME_BYTES = 1 + SPR_LINES * (SPR_WIDTH / 8);

  typedef enum logic [1:0] {COLOR, DATA, FULL, DRAIN} state_t;
endpackage

// File: rtl/sprite_bank.sv
// One sprite bank: single write port, registered read port, no reset on storage.
module sprite_bank #(
  parameter int DEPTH = 48,
  parameter int WIDTH = 64,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/sprite_store.sv
// Double-buffered sprite store: a byte loader fills the back bank while the VGA
// stage reads the front bank; banks exchange on a vsync fall once a frame is complete.
module sprite_store #(
  parameter int SPR_LINES = sprite_pkg::SPR_LINES,
  parameter int SPR_WIDTH = sprite_pkg::SPR_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  input  logic                 vsync,
  input  logic [6:0]           readaddress,
  output logic [SPR_WIDTH-1:0] readata,
  output logic [2:0]           rgb,
  output logic                 swap_done,
  output logic                 frame_err
);
  import sprite_pkg::state_t;
  import sprite_pkg::COLOR;
  import sprite_pkg::DATA;
  import sprite_pkg::FULL;
  import sprite_pkg::DRAIN;

  localparam int LW = $clog2(SPR_LINES);

  state_t               state, state_nx;
  logic                 vsync_q, vsync_fall, accept, last_byte;
  logic [2:0]           byte_idx;
  logic [LW-1:0]        line_idx, wr_addr;
  logic [SPR_WIDTH-1:0] line_buf, rd0, rd1;
  logic                 wr_en, sel, sel_q, front_valid, addr_ok_q;
  logic [2:0]           rgb_pend;
  logic                 err_nx, swap_nx;

  assign in_ready   = (state != FULL);
  assign accept     = in_valid && in_ready;
  assign vsync_fall = vsync_q && !vsync;
  assign last_byte  = (line_idx == LW'(SPR_LINES - 1)) && (byte_idx == 3'd7);

  always_comb begin
    state_nx = state;
    err_nx   = 1'b0;
    swap_nx  = 1'b0;
    case (state)
      COLOR: if (accept) begin
        if (in_last) err_nx = 1'b1;
        else         state_nx = DATA;
      end
      DATA: if (accept) begin
        if (last_byte) begin
          if (in_last) state_nx = FULL;
          else begin err_nx = 1'b1; state_nx = DRAIN; end
        end else if (in_last) begin
          err_nx   = 1'b1;
          state_nx = COLOR;
        end
      end
      FULL: if (vsync_fall) begin
        swap_nx  = 1'b1;
        state_nx = COLOR;
      end
      DRAIN: if (accept && in_last) state_nx = COLOR;
      default: state_nx = COLOR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= COLOR;
      vsync_q     <= 1'b0;
      byte_idx    <= '0;
      line_idx    <= '0;
      line_buf    <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      sel         <= 1'b0;
      sel_q       <= 1'b0;
      front_valid <= 1'b0;
      addr_ok_q   <= 1'b0;
      rgb_pend    <= '0;
      rgb         <= '0;
      swap_done   <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state     <= state_nx;
      vsync_q   <= vsync;
      swap_done <= swap_nx;
      frame_err <= err_nx;
      wr_en     <= 1'b0;
      sel_q     <= sel;
      addr_ok_q <= front_valid && (readaddress < 7'(SPR_LINES));
      if (state == COLOR) begin
        byte_idx <= '0;
        line_idx <= '0;
        if (accept && !in_last) rgb_pend <= in_data[2:0];
      end
      if (state == DATA && accept) begin
        line_buf[{byte_idx, 3'b000} +: 8] <= in_data;
        byte_idx <= byte_idx + 3'd1;
        // Line commits next cycle, once line_buf holds all eight bytes.
        if (byte_idx == 3'd7) begin
          wr_en   <= 1'b1;
          wr_addr <= line_idx;
          if (!last_byte) line_idx <= line_idx + 1'b1;
        end
      end
      if (swap_nx) begin
        sel         <= ~sel;
        front_valid <= 1'b1;
        rgb         <= rgb_pend;
      end
    end
  end

  // sel = 0: bank0 is front, bank1 is back.
  sprite_bank #(.DEPTH(SPR_LINES), .WIDTH(SPR_WIDTH), .AW(LW)) u_bank0 (
    .clk(clk), .we(wr_en && sel), .waddr(wr_addr), .wdata(line_buf),
    .raddr(readaddress[LW-1:0]), .rdata(rd0)
  );
  sprite_bank #(.DEPTH(SPR_LINES), .WIDTH(SPR_WIDTH), .AW(LW)) u_bank1 (
    .clk(clk), .we(wr_en && !sel), .waddr(wr_addr), .wdata(line_buf),
    .raddr(readaddress[LW-1:0]), .rdata(rd1)
  );

  assign readata = addr_ok_q ? (sel_q ? rd1 : rd0) : '0;
endmodule

// File: tb/tb_sprite_store.sv
// Directed bench for sprite_store: frame-level model compared every cycle plus literal spot checks.
module tb_sprite_store;
  import sprite_pkg::*;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_last, in_ready, vsync, swap_done, frame_err;
  logic [7:0]  in_data;
  logic [6:0]  readaddress;
  logic [63:0] readata;
  logic [2:0]  rgb;

  always #5 clk = ~clk;

  sprite_store dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .vsync(vsync), .readaddress(readaddress), .readata(readata),
    .rgb(rgb), .swap_done(swap_done), .frame_err(frame_err)
  );

  int vecs = 0, miss = 0, swap_cnt = 0, err_cnt = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level model: m_cnt counts bytes taken of the current frame (0 = expecting colour).
  logic [63:0] m_back [SPR_LINES];
  logic [63:0] m_front [SPR_LINES];
  logic [63:0] m_rd;
  logic [2:0]  m_pend, m_rgb;
  int          m_cnt;
  bit          m_full, m_drain, m_fv, m_vs, m_swap, m_err;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt <= 0; m_full <= 0; m_drain <= 0; m_fv <= 0; m_vs <= 0;
      m_swap <= 0; m_err <= 0; m_rgb <= '0; m_pend <= '0; m_rd <= '0;
    end else begin
      m_swap <= 0;
      m_err  <= 0;
      m_vs   <= vsync;
      m_rd   <= (m_fv && readaddress < 7'(SPR_LINES)) ? m_front[readaddress[5:0]] : '0;
      if (m_full) begin
        if (m_vs && !vsync) begin
          for (int i = 0; i < SPR_LINES; i++) m_front[i] <= m_back[i];
          m_fv <= 1; m_rgb <= m_pend; m_full <= 0; m_swap <= 1;
        end
      end else if (in_valid) begin
        if (m_drain) begin
          if (in_last) m_drain <= 0;
        end else if (m_cnt == 0) begin
          if (in_last) m_err <= 1;
          else begin m_pend <= in_data[2:0]; m_cnt <= 1; end
        end else begin
          m_back[(m_cnt-1)/8][((m_cnt-1)%8)*8 +: 8] <= in_data;
          if (m_cnt == FRAME_BYTES - 1) begin
            m_cnt <= 0;
            if (in_last) m_full <= 1;
            else begin m_err <= 1; m_drain <= 1; end
          end else if (in_last) begin
            m_err <= 1; m_cnt <= 0;
          end else m_cnt <= m_cnt + 1;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("in_ready",  64'(in_ready),  64'(!m_full));
      chk("rgb",       64'(rgb),       64'(m_rgb));
      chk("swap_done", 64'(swap_done), 64'(m_swap));
      chk("frame_err", 64'(frame_err), 64'(m_err));
      chk("readata",   readata,        m_rd);
      if (swap_done === 1'b1) swap_cnt++;
      if (frame_err === 1'b1) err_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit last, input bit vs_low);
    bit done = 0;
    in_valid = 1; in_data = d; in_last = last;
    if (vs_low) vsync = 0;
    for (int n = 0; n < 100 && !done; n++) begin
      done = in_ready;
      tick();
    end
    if (!done) begin
      vecs++; miss++;
      $display("FAIL send_byte timeout: in_ready=%b want 1", in_ready);
    end
    in_valid = 0; in_last = 0; vsync = 1;
  endtask

  task automatic send_frame(input logic [2:0] col, input int ndata, input int last_at,
                            input int seed, input bit vs_on_last);
    send_byte({5'b10101, col}, 0, 0);
    for (int i = 0; i < ndata; i++)
      send_byte(8'(i + seed), i == last_at, vs_on_last && i == last_at);
  endtask

  task automatic vs_fall();
    vsync = 0; tick(); vsync = 1; tick();
  endtask

  task automatic read_line(input logic [6:0] a);
    readaddress = a; tick();
  endtask

  initial begin
    rst = 1; in_valid = 0; in_data = '0; in_last = 0; vsync = 1; readaddress = '0;
    tick(); chk_en = 1; tick();
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_readata", readata, 64'd0);
    chk("rst_rgb", 64'(rgb), 64'd0);
    chk("rst_pulses", 64'({swap_done, frame_err}), 64'd0);
    rst = 0; tick();

    // nothing shown before the first swap
    read_line(7'd0);  chk("preswap_0", readata, 64'd0);
    read_line(7'd47); chk("preswap_47", readata, 64'd0);

    // good frame, then backpressure while FULL
    send_frame(3'b101, FRAME_BYTES - 1, FRAME_BYTES - 2, 0, 0);
    tick(); chk("full_ready", 64'(in_ready), 64'd0);
    in_valid = 1; in_data = 8'hFF; in_last = 1;
    for (int i = 0; i < 6; i++) begin tick(); chk("bp_ready", 64'(in_ready), 64'd0); end
    in_valid = 0; in_last = 0;
    chk("no_swap_yet", 64'(swap_cnt), 64'd0);
    vs_fall();
    chk("swap1", 64'(swap_cnt), 64'd1);
    chk("rgb101", 64'(rgb), 64'd5);
    chk("no_err", 64'(err_cnt), 64'd0);
    read_line(7'd0);   chk("line0", readata, 64'h0706050403020100);
    read_line(7'd47);  chk("line47", readata, 64'h7F7E7D7C7B7A7978);
    read_line(7'd48);  chk("addr48", readata, 64'd0);
    read_line(7'd127); chk("addr127", readata, 64'd0);

    // early in_last on data byte 10
    send_frame(3'b010, 10, 9, 8'h30, 0);
    tick(); chk("early_err", 64'(err_cnt), 64'd1);
    chk("early_ready", 64'(in_ready), 64'd1);
    vs_fall(); chk("early_noswap", 64'(swap_cnt), 64'd1);
    read_line(7'd0); chk("early_keep", readata, 64'h0706050403020100);

    // missing in_last, drain 5 bytes, then a frame whose last byte meets a vsync fall
    send_frame(3'b010, FRAME_BYTES - 1, -1, 8'h40, 0);
    for (int i = 0; i < 5; i++) send_byte(8'(8'hE0 + i), i == 4, 0);
    tick(); chk("drain_err", 64'(err_cnt), 64'd2);
    send_frame(3'b011, FRAME_BYTES - 1, FRAME_BYTES - 2, 8'h80, 1);
    tick(); tick();
    chk("coincident_noswap", 64'(swap_cnt), 64'd1);
    chk("coincident_full", 64'(in_ready), 64'd0);
    vs_fall();
    chk("swap2", 64'(swap_cnt), 64'd2);
    chk("rgb011", 64'(rgb), 64'd3);
    read_line(7'd0);  chk("f2_line0", readata, 64'h8786858483828180);
    read_line(7'd47); chk("f2_line47", readata, 64'hFFFEFDFCFBFAF9F8);
    chk("drain_err_once", 64'(err_cnt), 64'd2);

    // reset in the middle of a frame
    readaddress = 7'd0;
    send_frame(3'b110, 200, -1, 0, 0);
    rst = 1; tick();
    chk("mid_rst_readata", readata, 64'd0);
    chk("mid_rst_rgb", 64'(rgb), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_pulses", 64'({swap_done, frame_err}), 64'd0);
    rst = 0; tick();
    vs_fall();
    chk("mid_rst_noswap", 64'(swap_cnt), 64'd2);
    chk("mid_rst_noerr", 64'(err_cnt), 64'd2);
    read_line(7'd0); chk("mid_rst_hidden", readata, 64'd0);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
